// File: rtl/pipe_chain_pkg.sv
// Shared defaults, stage index names and helpers for the elastic pipeline chain.
package pipe_chain_pkg;

    localparam int STAGES_DEF = 5;
    localparam int WIDTH_DEF  = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [3:0] {
        IF = 4'd0,
        ID = 4'd1,
        EX = 4'd2,
        ME = 4'd3,
        WB = 4'd4
    } stage_idx_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_chain_stage_reg.sv
// One pipeline stage: valid bit plus payload register with load/clear/flush controls.
module pipe_stage_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             load,
    input  logic             clear,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             valid_nxt
);

    // Flush wins over load; clear marks a stage that drained without refill.
    always_comb begin
        valid_nxt = valid;
        if (flush) begin
            valid_nxt = 1'b0;
        end else if (load) begin
            valid_nxt = 1'b1;
        end else if (clear) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid_nxt;
            if (load && !flush) begin
                data <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Elastic pipeline backbone: STAGES valid+payload registers with per-stage stall/flush
// and valid/ready handshakes at both ends.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                         clock,
    input  logic                         reset_0,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic [STAGES-1:0]            stall_req,
    input  logic [STAGES-1:0]            flush_vec,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*WIDTH-1:0]      stage_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]             retire_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] clear;
    logic [STAGES-1:0] valid_nxt;
    logic [WIDTH-1:0]  data_q [STAGES];

    // Ready resolves from the consumer backwards so a draining stage can refill same cycle.
    always_comb begin
        rdy   = '0;
        adv   = '0;
        load  = '0;
        clear = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES-1; i >= 0; i--) begin
            adv[i] = stage_valid[i] & ~stall_req[i] & rdy[i+1];
            rdy[i] = ~stage_valid[i] | adv[i];
        end
        load[0] = in_valid & rdy[0];
        for (int i = 1; i < STAGES; i++) begin
            load[i] = adv[i-1];
        end
        clear = adv & ~load;
    end

    assign in_ready  = rdy[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] d_in;
        if (g == 0) begin : g_head
            assign d_in = in_data;
        end else begin : g_body
            assign d_in = data_q[g-1];
        end

        pipe_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clock     (clock),
            .reset_0   (reset_0),
            .load      (load[g]),
            .clear     (clear[g]),
            .flush     (flush_vec[g]),
            .d         (d_in),
            .valid     (stage_valid[g]),
            .data      (data_q[g]),
            .valid_nxt (valid_nxt[g])
        );

        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            occupancy  <= '0;
            retire_cnt <= '0;
        end else begin
            occupancy <= OCC_W'(popcount16(16'(valid_nxt)));
            if (out_valid && out_ready) begin
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus randomized traffic
// against a slot-level reference model.
module tb_pipe_chain;

    localparam int S = 5;
    localparam int W = 16;
    localparam int C = 4;

    logic                 clock = 1'b0;
    logic                 reset_0 = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W-1:0]         in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [W-1:0]         out_data;
    logic [S-1:0]         stall_req = '0;
    logic [S-1:0]         flush_vec = '0;
    logic [S-1:0]         stage_valid;
    logic [S*W-1:0]       stage_data;
    logic [$clog2(S+1)-1:0] occupancy;
    logic [C-1:0]         retire_cnt;

    pipe_chain #(.STAGES(S), .WIDTH(W), .CNT_W(C)) dut (
        .clock       (clock),
        .reset_0     (reset_0),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall_req   (stall_req),
        .flush_vec   (flush_vec),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy),
        .retire_cnt  (retire_cnt)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_fail = 0;

    // Reference model: one slot per stage, plus total retirements.
    logic         m_v [S];
    logic [W-1:0] m_d [S];
    int           m_retired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = '0;
        end
        m_retired = 0;
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < S; i++) n += int'(m_v[i]);
        return n;
    endfunction

    task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                         input logic [S-1:0] st, input logic [S-1:0] fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall_req = st;
        flush_vec = fl;
    endtask

    // One clock: check combinational outputs, step the model, check registered state.
    task automatic cycle();
        logic [S-1:0] moves;
        logic         space;
        logic         nv [S];
        logic [W-1:0] nd [S];
        logic         takes;
        #1;
        // A word moves on if its slot is occupied, not stalled and the next slot frees up.
        space = out_ready;
        for (int i = S-1; i >= 0; i--) begin
            moves[i] = m_v[i] && !stall_req[i] && space;
            space    = !m_v[i] || moves[i];
        end
        chk("in_ready", {31'd0, in_ready}, {31'd0, space});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_v[S-1]});
        if (m_v[S-1]) chk("out_data", 32'(out_data), 32'(m_d[S-1]));
        if (m_v[S-1] && out_ready) m_retired++;
        for (int i = 0; i < S; i++) begin
            nv[i] = m_v[i] && !moves[i];
            nd[i] = m_d[i];
            takes = (i == 0) ? (in_valid && space) : moves[i-1];
            if (takes) begin
                nv[i] = 1'b1;
                nd[i] = (i == 0) ? in_data : m_d[i-1];
            end
            if (flush_vec[i]) nv[i] = 1'b0;
        end
        for (int i = 0; i < S; i++) begin
            m_v[i] = nv[i];
            m_d[i] = nd[i];
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < S; i++) begin
            chk($sformatf("stage_valid[%0d]", i), {31'd0, stage_valid[i]}, {31'd0, m_v[i]});
            if (m_v[i]) chk($sformatf("stage_data[%0d]", i), 32'(stage_data[i*W +: W]), 32'(m_d[i]));
        end
        chk("occupancy", 32'(occupancy), 32'(model_count()));
        chk("retire_cnt", 32'(retire_cnt), 32'(m_retired % (1 << C)));
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_0 = 1'b0;
        model_reset();
        @(negedge clock);
        reset_0 = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w1;
        int           r0;

        model_reset();
        drive(1'b0, '0, 1'b0, '0, '0);
        repeat (2) @(negedge clock);
        reset_0 = 1'b1;
        #1;
        chk("reset_valid", 32'(stage_valid), 32'd0);
        chk("reset_occ", 32'(occupancy), 32'd0);
        chk("reset_retire", 32'(retire_cnt), 32'd0);

        // Back-to-back stream of 0x11..0x18: first word out five cycles after acceptance.
        for (int k = 0; k < 14; k++) begin
            drive(k < 8, W'(16'h11 + k), 1'b1, '0, '0);
            #1;
            if (k == 4) chk("t2_not_yet", {31'd0, out_valid}, 32'd0);
            if (k == 5) chk("t2_first_out", 32'(out_data), 32'h11);
            cycle();
        end
        chk("t2_retired", 32'(retire_cnt), 32'd8);

        // Asynchronous reset with three words in flight.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, W'($urandom), 1'b0, '0, '0);
            cycle();
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        #2;
        reset_0 = 1'b0;
        #1;
        chk("t1_valid", 32'(stage_valid), 32'd0);
        chk("t1_occ", 32'(occupancy), 32'd0);
        chk("t1_retire", 32'(retire_cnt), 32'd0);
        model_reset();
        @(negedge clock);
        reset_0 = 1'b1;

        // Backpressure: consumer stalls for six cycles while the producer keeps offering.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, W'($urandom), 1'b0, '0, '0);
            cycle();
        end
        #1;
        chk("t4_occ_full", 32'(occupancy), 32'd5);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b1, '0, '0);
            cycle();
        end

        // Load-use stall on stage 1 with a full pipe.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, W'($urandom), 1'b0, '0, '0);
            cycle();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, W'($urandom), 1'b1, 5'b00010, '0);
            #1;
            chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
            cycle();
        end
        chk("t3_occ", 32'(occupancy), 32'd3);
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, '0, 1'b1, '0, '0);
            cycle();
        end

        // Branch flush of stages 0 and 1 while the pipe is streaming.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, W'($urandom), 1'b0, '0, '0);
            cycle();
        end
        w1 = m_d[1];
        drive(1'b1, W'($urandom), 1'b1, '0, 5'b00011);
        cycle();
        chk("t5_front_invalid", 32'(stage_valid[1:0]), 32'd0);
        chk("t5_stage2_valid", {31'd0, stage_valid[2]}, 32'd1);
        chk("t5_stage2_data", 32'(stage_data[2*W +: W]), 32'(w1));

        // Flush of the last stage during an out handshake still counts as retired.
        r0 = int'(retire_cnt);
        drive(1'b0, '0, 1'b1, '0, 5'b10000);
        cycle();
        chk("t6_flush_retire", 32'(retire_cnt), 32'((r0 + 1) % (1 << C)));
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, '0, 1'b1, '0, '0);
            cycle();
        end

        // Counter wrap: 17 retirements on a 4-bit counter.
        do_reset();
        for (int k = 0; k < 23; k++) begin
            drive(k < 17, W'(k), 1'b1, '0, '0);
            cycle();
        end
        chk("t6_wrap", 32'(retire_cnt), 32'd1);

        // Randomized traffic with sparse stalls and flushes.
        for (int k = 0; k < 400; k++) begin
            logic [S-1:0] st;
            logic [S-1:0] fl;
            for (int i = 0; i < S; i++) begin
                st[i] = ($urandom_range(0, 7) == 0);
                fl[i] = ($urandom_range(0, 15) == 0);
            end
            drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0, st, fl);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
